// File: rtl/stream_demux_pkg.sv
// Shared types and default parameters for the 1-to-N valid/ready stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int N_OUTS_DEF = 4;
  localparam int W_DEF      = 8;

endpackage

// File: rtl/demux_1_to_n.sv
// Combinational binary-select to one-hot decoder gated by a single enable input.
module demux_1_to_n #(
  parameter int N_OUTS = 4,
  parameter int SEL_W  = $clog2(N_OUTS)
) (
  input  logic              in,
  input  logic [SEL_W-1:0]  sel,
  output logic [N_OUTS-1:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUTS; gi++) begin : g_out
      assign out[gi] = in && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/stream_demux_1_to_n.sv
// Packet-aware 1-to-N stream demultiplexer with a single registered output stage.
// Destination is chosen on the first beat and held for the rest of the packet.
module stream_demux_1_to_n
  import stream_demux_pkg::*;
#(
  parameter int N_OUTS = N_OUTS_DEF,
  parameter int W      = W_DEF,
  parameter int SEL_W  = $clog2(N_OUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [W-1:0]      up_data,
  input  logic              up_last,
  input  logic [SEL_W-1:0]  up_sel,
  output logic [N_OUTS-1:0] down_valid,
  input  logic [N_OUTS-1:0] down_ready,
  output logic [W-1:0]      down_data,
  output logic              down_last,
  output logic              drop
);

  state_t             state_reg, state_next;
  logic               full_reg, full_next;
  logic [W-1:0]       data_reg, data_next;
  logic               last_reg, last_next;
  logic [SEL_W-1:0]   dest_reg, dest_next;
  logic               drop_reg, drop_next;

  logic [N_OUTS-1:0]  dest_onehot;
  logic               dest_ready;
  logic               sel_ok;
  logic               accept;

  demux_1_to_n #(.N_OUTS(N_OUTS), .SEL_W(SEL_W)) u_valid_demux (
    .in  (full_reg),
    .sel (dest_reg),
    .out (down_valid)
  );

  demux_1_to_n #(.N_OUTS(N_OUTS), .SEL_W(SEL_W)) u_ready_demux (
    .in  (1'b1),
    .sel (dest_reg),
    .out (dest_onehot)
  );

  assign dest_ready = |(dest_onehot & down_ready);

  // An out-of-range select is only possible when N_OUTS leaves unused codes.
  generate
    if ((1 << SEL_W) == N_OUTS) begin : g_pow2
      assign sel_ok = 1'b1;
    end else begin : g_npow2
      assign sel_ok = (up_sel < SEL_W'(N_OUTS));
    end
  endgenerate

  assign up_ready = (state_reg == DROP) || !full_reg || dest_ready;
  assign accept   = up_valid && up_ready;

  always_comb begin
    state_next = state_reg;
    full_next  = full_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    dest_next  = dest_reg;
    drop_next  = 1'b0;

    if (full_reg && dest_ready) begin
      full_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (sel_ok) begin
            full_next = 1'b1;
            data_next = up_data;
            last_next = up_last;
            dest_next = up_sel;
            if (!up_last) state_next = PKT;
          end else begin
            drop_next = 1'b1;
            if (!up_last) state_next = DROP;
          end
        end
      end
      // dest_reg still holds the destination latched on the first beat.
      PKT: begin
        if (accept) begin
          full_next = 1'b1;
          data_next = up_data;
          last_next = up_last;
          if (up_last) state_next = IDLE;
        end
      end
      DROP: begin
        if (accept) begin
          drop_next = 1'b1;
          if (up_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      full_reg  <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      dest_reg  <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      full_reg  <= full_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      dest_reg  <= dest_next;
      drop_reg  <= drop_next;
    end
  end

  assign down_data = data_reg;
  assign down_last = last_reg;
  assign drop      = drop_reg;

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Scoreboard bench: a 4-channel instance for routing/lock/back-pressure/reset, a 3-channel one for drops.
module tb_stream_demux_1_to_n;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_data = '0;
  logic       up_last = 1'b0;
  logic [1:0] up_sel = '0;
  logic [3:0] down_ready = 4'hF;

  logic       up_valid4 = 1'b0;
  logic       up_ready4;
  logic [3:0] down_valid4;
  logic [7:0] down_data4;
  logic       down_last4;
  logic       drop4;

  logic       up_valid3 = 1'b0;
  logic       up_ready3;
  logic [2:0] down_valid3;
  logic [7:0] down_data3;
  logic       down_last3;
  logic       drop3;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  beat_t sb_q[$];

  always #5 clk = ~clk;

  stream_demux_1_to_n #(.N_OUTS(4), .W(8)) dut4 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid4), .up_ready(up_ready4), .up_data(up_data),
    .up_last(up_last), .up_sel(up_sel),
    .down_valid(down_valid4), .down_ready(down_ready),
    .down_data(down_data4), .down_last(down_last4), .drop(drop4)
  );

  stream_demux_1_to_n #(.N_OUTS(3), .W(8)) dut3 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid3), .up_ready(up_ready3), .up_data(up_data),
    .up_last(up_last), .up_sel(up_sel),
    .down_valid(down_valid3), .down_ready(down_ready[2:0]),
    .down_data(down_data3), .down_last(down_last3), .drop(drop3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit to3, input logic [1:0] sel, input logic [7:0] d,
                      input logic l, input logic [1:0] exp_ch, output int waits);
    beat_t e;
    bit    rdy;
    waits = 0;
    up_sel = sel; up_data = d; up_last = l;
    if (to3) up_valid3 = 1'b1; else up_valid4 = 1'b1;
    forever begin
      @(negedge clk);
      rdy = to3 ? up_ready3 : up_ready4;
      if (rdy) break;
      waits++;
      if (waits >= 50) begin
        chk("accept_timeout", 32'(waits), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk);
    if (rdy && !to3) begin
      e.ch = exp_ch; e.data = d; e.last = l;
      sb_q.push_back(e);
    end
    #1;
    up_valid4 = 1'b0;
    up_valid3 = 1'b0;
  endtask

  // Every beat handed over on the 4-channel instance is matched against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && |(down_valid4 & down_ready)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 32'(down_valid4), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("down_valid", 32'(down_valid4), 32'(4'b0001 << e.ch));
        chk("down_data", 32'(down_data4), 32'(e.data));
        chk("down_last", 32'(down_last4), 32'(e.last));
      end
    end
  end

  initial begin
    int w;
    up_valid4 = 1'b1;
    up_valid3 = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_down_valid", 32'(down_valid4), 32'd0);
    chk("rst_drop", 32'(drop4), 32'd0);
    chk("rst_down_valid3", 32'(down_valid3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    up_valid4 = 1'b0;
    up_valid3 = 1'b0;
    @(negedge clk);
    chk("rst_up_ready", 32'(up_ready4), 32'd1);
    chk("rst_down_data", 32'(down_data4), 32'd0);
    chk("rst_down_last", 32'(down_last4), 32'd0);
    chk("rst_drop_after", 32'(drop4), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      send(1'b0, 2'(i), 8'hA0 + 8'(i), 1'b1, 2'(i), w);
      chk("route_waits", 32'(w), 32'd0);
    end

    send(1'b0, 2'd2, 8'h11, 1'b0, 2'd2, w);
    send(1'b0, 2'd1, 8'h22, 1'b0, 2'd2, w);
    send(1'b0, 2'd1, 8'h33, 1'b1, 2'd2, w);

    down_ready = 4'b1101;
    send(1'b0, 2'd1, 8'h41, 1'b0, 2'd1, w);
    up_sel = 2'd1; up_data = 8'h42; up_last = 1'b0; up_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_up_ready", 32'(up_ready4), 32'd0);
      chk("bp_data_hold", 32'(down_data4), 32'h41);
      chk("bp_valid_hold", 32'(down_valid4), 32'b0010);
      @(posedge clk); #1;
    end
    down_ready = 4'hF;
    send(1'b0, 2'd1, 8'h42, 1'b0, 2'd1, w);
    chk("bp_resume_waits", 32'(w), 32'd0);
    send(1'b0, 2'd0, 8'h43, 1'b0, 2'd1, w);
    chk("bp_resume_waits", 32'(w), 32'd0);
    send(1'b0, 2'd3, 8'h44, 1'b1, 2'd1, w);
    chk("bp_resume_waits", 32'(w), 32'd0);

    send(1'b1, 2'd3, 8'hD1, 1'b0, 2'd0, w);
    @(negedge clk);
    chk("oor_drop1", 32'(drop3), 32'd1);
    chk("oor_valid1", 32'(down_valid3), 32'd0);
    @(posedge clk); #1;
    send(1'b1, 2'd0, 8'hD2, 1'b1, 2'd0, w);
    @(negedge clk);
    chk("oor_drop2", 32'(drop3), 32'd1);
    chk("oor_valid2", 32'(down_valid3), 32'd0);
    @(posedge clk); #1;
    send(1'b1, 2'd0, 8'h99, 1'b1, 2'd0, w);
    @(negedge clk);
    chk("oor_next_drop", 32'(drop3), 32'd0);
    chk("oor_next_valid", 32'(down_valid3), 32'b001);
    chk("oor_next_data", 32'(down_data3), 32'h99);
    @(posedge clk); #1;

    send(1'b0, 2'd1, 8'h51, 1'b0, 2'd1, w);
    up_sel = 2'd1; up_data = 8'h52; up_last = 1'b0; up_valid4 = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    up_valid4 = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(down_valid4), 32'd0);
    @(posedge clk); #1;
    send(1'b0, 2'd3, 8'h77, 1'b1, 2'd3, w);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
